disp_scan_ctrl: RTL
===================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4: clk cycles per digit slot; legal values 2..255.
REQ-002 The block SHALL have port clk, input, width 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port wr_en, input, width 1: write strobe for a digit register, sampled each rising edge.
REQ-005 The block SHALL have port wr_addr, input, width 2: digit index written (0 = rightmost).
REQ-006 The block SHALL have port wr_hex, input, width 1: 1 = decode wr_data[3:0] as hex, 0 = wr_data is a raw segment pattern.
REQ-007 The block SHALL have port wr_data, input, width 8: raw pattern bit0=a .. bit6=g, bit7=dp; in hex mode only [3:0] (nibble) and [7] (dp) are used.
REQ-008 The block SHALL have port blank, input, width 1: registered display blank request.
REQ-009 The block SHALL have port seg, output, width 8: active-high segment bus, same bit order as wr_data.
REQ-010 The block SHALL have port an, output, width 4: active-high one-hot digit enable.
REQ-011 The block SHALL have port frame_done, output, width 1: one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-012 State SHALL be: cnt (prescaler, 0..PRESCALE-1), idx (2-bit scan index), dreg[0..3] (8-bit), blank_q; all outputs SHALL be decoded from registered state only, with no combinational input-to-output path.
REQ-013 cnt SHALL increment every cycle and wrap PRESCALE-1 -> 0; on each wrap idx SHALL advance 0->1->2->3->0.
REQ-014 When cnt==0 (guard cycle), an SHALL be 4'b0000 and seg SHALL be 8'h00 to suppress ghosting.
REQ-015 When cnt!=0, an SHALL be one-hot(idx) and seg SHALL be dreg[idx], unless blank_q==1, in which case an=0 and seg=0.
REQ-016 frame_done SHALL be 1 exactly in the cycle where cnt==PRESCALE-1 and idx==3, giving a period of 4*PRESCALE cycles; it SHALL pulse even while blanked.
REQ-017 A write with wr_en=1 SHALL update dreg[wr_addr] at that edge and be visible on seg from the next cycle if that digit is being driven; 1-cycle write latency; no handshake or back-pressure.
REQ-018 Hex mode SHALL store {wr_data[7], pattern}, with patterns 0-F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex, bits 6:0).
REQ-019 A write coinciding with a slot advance SHALL apply both; the new slot SHALL show the new data if addresses match.
REQ-020 Back-to-back writes SHALL be accepted every cycle; the last write to an address wins.
REQ-021 blank_q SHALL load blank every cycle; blanking SHALL NOT alter cnt, idx or dreg.

Reset
REQ-022 With rst=1 at an edge, the block SHALL set cnt=0, idx=0, all dreg=8'h00, blank_q=0 and zero flags clear; rst SHALL take priority over a simultaneous wr_en.
REQ-023 In the cycle after reset release, outputs SHALL be an=0, seg=0, frame_done=0 (guard cycle of digit 0).
REQ-024 Reset asserted mid-scan SHALL abort the slot; scanning SHALL restart at digit 0, cnt 0.

Configuration
REQ-025 The block SHALL support macro DISP_LZB_EN, which adds leading-zero blanking.
REQ-026 With DISP_LZB_EN defined, each digit SHALL hold a zero flag, set by a hex-mode write of nibble 0 with dp=0 and cleared by any other write; digit k (k=3..1) SHALL be suppressed (an=0, seg=0 in its slot) when the zero flags of digits 3..k are all set; digit 0 SHALL never be suppressed.
REQ-027 Without DISP_LZB_EN, the zero-flag logic SHALL be absent and all digits SHALL display per REQ-015.

Verification (PRESCALE=4)
REQ-028 The bench SHALL check: reset, then hex-write digits 0..3 = 1,2,3,4 -> over one frame, seg sequence 06,5B,4F,66 with an 0001,0010,0100,1000, each for 3 cycles after a 1-cycle guard; frame_done every 16 cycles.
REQ-029 The bench SHALL check: raw write addr 2, data 8'h80 during digit 2 slot -> seg=80 from the next cycle within the same slot.
REQ-030 The bench SHALL check: blank=1 for 10 cycles -> an=0, seg=0 from the cycle after assertion; frame_done cadence unchanged; display resumes with the same contents.
REQ-031 The bench SHALL check: rst pulsed while idx=2, cnt=2 -> next cycle an=0, seg=0; all digits then read 00; the scan restarts at digit 0.
REQ-032 The bench SHALL check, with DISP_LZB_EN defined: hex-write digits 3,2,1,0 = 0,0,5,0 -> digits 3 and 2 dark, digit 1 shows 6D, digit 0 shows 3F; without the macro, digits 3 and 2 show 3F.
REQ-033 The bench SHALL check: simultaneous rst=1 and wr_en=1 (addr 0, hex 8) -> dreg[0] stays 00.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Each digit owns a slot of PRESCALE clocks. The first clock of a slot is a
// dark guard cycle that suppresses ghosting. Digit registers are written as
// raw segment patterns or as hex nibbles, and the display can be blanked.
//
// Optional feature: define DISP_LZB_EN to add leading-zero blanking.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   wr_en      - write strobe for digit register wr_addr
//   wr_addr    - digit index written (0 = rightmost)
//   wr_hex     - 1: decode wr_data[3:0] as hex (dp from wr_data[7]); 0: raw pattern
//   wr_data    - raw pattern bit0=a .. bit6=g, bit7=dp
//   blank      - display blank request, registered
//   seg        - active-high segment bus, same bit order as wr_data
//   an         - active-high one-hot digit enable
//   frame_done - one-cycle pulse in the last cycle of each 4-digit scan
module disp_scan_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic       wr_hex,
    input  logic [7:0] wr_data,
    input  logic       blank,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NDIG    = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    // Registered state
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       dreg [NDIG];
    logic             blank_q;

    // Next-state signals
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       wr_val;
    logic             slot_end;

    // Per-digit suppression from leading-zero blanking (all zero when disabled)
    logic [NDIG-1:0]  sup_mask;

    // 7-segment patterns for hex digits, bits 6:0 = g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] p;
        case (nib)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Prescaler / scan index advance and write data formatting
    always_comb begin
        slot_end = (cnt == CNT_MAX);
        cnt_next = cnt + CNT_W'(1);
        idx_next = idx;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = idx + IDX_W'(1);
        end
        wr_val = wr_data;
        if (wr_hex) begin
            wr_val = {wr_data[7], hex_to_seg(wr_data[3:0])};
        end
    end

    // State registers; reset wins over a coincident write
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            blank_q <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                dreg[i] <= '0;
            end
        end else begin
            cnt     <= cnt_next;
            idx     <= idx_next;
            blank_q <= blank;
            if (wr_en) begin
                dreg[wr_addr] <= wr_val;
            end
        end
    end

`ifdef DISP_LZB_EN
    // Zero flag per digit: set by hex 0 without dp, cleared by any other write
    logic [NDIG-1:0] zflag;

    always_ff @(posedge clk) begin
        if (rst) begin
            zflag <= '0;
        end else if (wr_en) begin
            zflag[wr_addr] <= wr_hex && (wr_data[3:0] == 4'h0) && !wr_data[7];
        end
    end

    // Digit k is dark when it and every digit to its left hold a zero
    always_comb begin
        sup_mask    = '0;
        sup_mask[3] = zflag[3];
        sup_mask[2] = zflag[3] & zflag[2];
        sup_mask[1] = zflag[3] & zflag[2] & zflag[1];
    end
`else
    assign sup_mask = '0;
`endif

    // Output decode from registered state only
    always_comb begin
        seg        = '0;
        an         = '0;
        frame_done = slot_end && (idx == IDX_W'(3));
        if ((cnt != '0) && !blank_q && !sup_mask[idx]) begin
            seg = dreg[idx];
            an  = 4'b0001 << idx;
        end
    end

endmodule
